// File: rtl/execute_ctrl_pkg.sv
// rtl/execute_ctrl_pkg.sv - shared encodings for the execute-stage handshake controller
package execute_ctrl_pkg;

  localparam logic RESET_ENABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam int   OPC_BUS      = 2;

  typedef enum logic [1:0] {
    EXC_IDLE = 2'd0,
    EXC_EXEC = 2'd1,
    EXC_WAIT = 2'd2
  } exc_state_t;

  localparam logic [OPC_BUS-1:0] OPC_ALU = 2'd0;
  localparam logic [OPC_BUS-1:0] OPC_MUL = 2'd1;
  localparam logic [OPC_BUS-1:0] OPC_DIV = 2'd2;

  // Class code 3 is not a multi-cycle class, so it falls through to ALU handling.
  function automatic logic is_multicycle(input logic [OPC_BUS-1:0] cls);
    return (cls == OPC_MUL) || (cls == OPC_DIV);
  endfunction

endpackage

// File: rtl/execute_lat_cnt.sv
// rtl/execute_lat_cnt.sv - loadable down-counter with zero flag for multi-cycle latency
module execute_lat_cnt
  import execute_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_value,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);

  // Decrement stops at zero so a stalled count can never wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && !w_zero) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = w_zero;

endmodule

// File: rtl/execute_ctrl.sv
// rtl/execute_ctrl.sv - execute-stage handshake controller: decode accept, MUL/DIV sequencing,
// held result valid toward LSU/writeback
module execute_ctrl
  import execute_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_pre_i,
  output logic               ready_pre_o,
  input  logic [OPC_BUS-1:0] op_class_i,
  output logic               we_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               valid_post_o,
  input  logic               ready_post_i,
  input  logic               flush_i
);

  exc_state_t       r_state;
  exc_state_t       w_state_nxt;
  logic             r_start;
  logic             w_accept;
  logic             w_long;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_lat_m1;

  assign ready_pre_o  = (r_state == EXC_IDLE) ||
                        ((r_state == EXC_WAIT) && ready_post_i);
  assign busy_o       = (r_state == EXC_EXEC);
  assign valid_post_o = (r_state == EXC_WAIT);
  assign start_o      = r_start;

  assign w_accept = valid_pre_i && ready_pre_o && !flush_i;
  assign w_long   = w_accept && is_multicycle(op_class_i);
  assign w_lat_m1 = (op_class_i == OPC_DIV) ? CNT_W'(DIV_CYCLES - 1)
                                            : CNT_W'(MUL_CYCLES - 1);
  assign we_o     = w_accept ? WRITE_ENABLE : ~WRITE_ENABLE;

  execute_lat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clr   (flush_i),
    .i_load  (w_long),
    .i_dec   (busy_o),
    .i_value (w_lat_m1),
    .o_cnt   (w_cnt),
    .o_zero  (w_cnt_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      r_state <= EXC_IDLE;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_long;
    end
  end

  // Flush overrides everything, including a pending result handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EXC_IDLE: begin
        if (w_accept) w_state_nxt = w_long ? EXC_EXEC : EXC_WAIT;
      end
      EXC_EXEC: begin
        if (w_cnt_zero) w_state_nxt = EXC_WAIT;
      end
      EXC_WAIT: begin
        if (ready_post_i) begin
          if (w_accept) w_state_nxt = w_long ? EXC_EXEC : EXC_WAIT;
          else          w_state_nxt = EXC_IDLE;
        end
      end
      default: w_state_nxt = EXC_IDLE;
    endcase
    if (flush_i) w_state_nxt = EXC_IDLE;
  end

endmodule

// File: tb/tb_execute_ctrl.sv
// tb/tb_execute_ctrl.sv - scoreboard bench for execute_ctrl: expected event cycles queued, monitor compares
module tb_execute_ctrl;
  import execute_ctrl_pkg::*;

  logic               clock;
  logic               reset;
  logic               valid_pre_i;
  logic               ready_pre_o;
  logic [OPC_BUS-1:0] op_class_i;
  logic               we_o;
  logic               start_o;
  logic               busy_o;
  logic               valid_post_o;
  logic               ready_post_i;
  logic               flush_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int q_we[$];
  int q_start[$];
  int q_busy[$];
  int q_vld[$];

  execute_ctrl #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (33),
    .CNT_W      (6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .valid_pre_i  (valid_pre_i),
    .ready_pre_o  (ready_pre_o),
    .op_class_i   (op_class_i),
    .we_o         (we_o),
    .start_o      (start_o),
    .busy_o       (busy_o),
    .valid_post_o (valid_post_o),
    .ready_post_i (ready_post_i),
    .flush_i      (flush_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Each asserted output must match the next queued cycle; -1 flags an unexpected event.
  always @(negedge clock) begin
    int e;
    if (reset) begin
      if (we_o) begin
        e = (q_we.size() != 0) ? q_we.pop_front() : -1;
        chk("we_o cycle", cyc, e);
      end
      if (start_o) begin
        e = (q_start.size() != 0) ? q_start.pop_front() : -1;
        chk("start_o cycle", cyc, e);
      end
      if (busy_o) begin
        e = (q_busy.size() != 0) ? q_busy.pop_front() : -1;
        chk("busy_o cycle", cyc, e);
      end
      if (valid_post_o) begin
        e = (q_vld.size() != 0) ? q_vld.pop_front() : -1;
        chk("valid_post_o cycle", cyc, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b0; valid_pre_i = 1'b0; op_class_i = OPC_ALU;
    ready_post_i = 1'b1; flush_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset ready_pre_o", ready_pre_o, 1);
    chk("reset we_o", we_o, 0);
    chk("reset start_o", start_o, 0);
    chk("reset busy_o", busy_o, 0);
    chk("reset valid_post_o", valid_post_o, 0);
    reset = 1'b1;
    step();

    // single ALU op, immediate handshake
    step(); valid_pre_i = 1'b1; op_class_i = OPC_ALU; t = cyc;
    q_we.push_back(t); q_vld.push_back(t + 1);
    step(); valid_pre_i = 1'b0;
    step(); #3;
    chk("alu back to idle ready_pre_o", ready_pre_o, 1);
    chk("alu back to idle valid_post_o", valid_post_o, 0);

    // MUL: start at t+1, busy t+1..t+4, valid at t+5
    step(); valid_pre_i = 1'b1; op_class_i = OPC_MUL; t = cyc;
    q_we.push_back(t); q_start.push_back(t + 1); q_vld.push_back(t + 5);
    for (int i = 1; i <= 4; i++) q_busy.push_back(t + i);
    step(); valid_pre_i = 1'b0;
    repeat (6) step();

    // ALU result stalled 3 cycles; decode keeps offering and must be refused
    step(); valid_pre_i = 1'b1; op_class_i = OPC_ALU; ready_post_i = 1'b0; t = cyc;
    q_we.push_back(t);
    for (int i = 1; i <= 4; i++) q_vld.push_back(t + i);
    for (int k = 0; k < 3; k++) begin
      step(); op_class_i = OPC_MUL; #3;
      chk("stall ready_pre_o", ready_pre_o, 0);
    end
    step(); valid_pre_i = 1'b0; ready_post_i = 1'b1;
    step(); step();

    // five back-to-back ALU ops
    step(); valid_pre_i = 1'b1; op_class_i = OPC_ALU; ready_post_i = 1'b1; t = cyc;
    for (int i = 0; i < 5; i++) begin
      q_we.push_back(t + i);
      q_vld.push_back(t + 1 + i);
    end
    repeat (4) step();
    step(); valid_pre_i = 1'b0;
    step(); step();

    // flush blocks an accept in IDLE
    step(); valid_pre_i = 1'b1; op_class_i = OPC_ALU; flush_i = 1'b1; #3;
    chk("flush idle we_o", we_o, 0);
    step(); valid_pre_i = 1'b0; flush_i = 1'b0; #3;
    chk("flush idle valid_post_o", valid_post_o, 0);

    // DIV abandoned by flush at t+5
    step(); valid_pre_i = 1'b1; op_class_i = OPC_DIV; t = cyc;
    q_we.push_back(t); q_start.push_back(t + 1);
    for (int i = 1; i <= 5; i++) q_busy.push_back(t + i);
    step(); valid_pre_i = 1'b0;
    repeat (3) step();
    step(); flush_i = 1'b1; valid_pre_i = 1'b1; #3;
    chk("flush exec we_o", we_o, 0);
    step(); flush_i = 1'b0; valid_pre_i = 1'b0; #3;
    chk("after flush busy_o", busy_o, 0);
    chk("after flush ready_pre_o", ready_pre_o, 1);
    chk("after flush cnt", int'(dut.w_cnt), 0);
    repeat (3) step();
    step(); valid_pre_i = 1'b1; op_class_i = OPC_ALU; t = cyc;
    q_we.push_back(t); q_vld.push_back(t + 1);
    step(); valid_pre_i = 1'b0;
    step(); step();

    // async reset while DIV counter is at 20
    step(); valid_pre_i = 1'b1; op_class_i = OPC_DIV; t = cyc;
    q_we.push_back(t); q_start.push_back(t + 1);
    for (int i = 1; i <= 12; i++) q_busy.push_back(t + i);
    step(); valid_pre_i = 1'b0;
    repeat (12) step();
    #1;
    chk("div cnt before reset", int'(dut.w_cnt), 20);
    reset = 1'b0;
    #1;
    chk("async reset ready_pre_o", ready_pre_o, 1);
    chk("async reset busy_o", busy_o, 0);
    chk("async reset valid_post_o", valid_post_o, 0);
    chk("async reset start_o", start_o, 0);
    chk("async reset cnt", int'(dut.w_cnt), 0);
    step(); step(); reset = 1'b1; #3;
    chk("post reset ready_pre_o", ready_pre_o, 1);
    chk("post reset cnt", int'(dut.w_cnt), 0);
    step(); valid_pre_i = 1'b1; op_class_i = 2'd3; t = cyc;
    q_we.push_back(t); q_vld.push_back(t + 1);
    step(); valid_pre_i = 1'b0;
    repeat (3) step();

    chk("pending we_o events", q_we.size(), 0);
    chk("pending start_o events", q_start.size(), 0);
    chk("pending busy_o events", q_busy.size(), 0);
    chk("pending valid_post_o events", q_vld.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
